// File: rtl/fifo_burst_reader.sv
// Show-ahead FIFO drain into a valid/ready stream framed as BURST_LEN-word bursts.
// Optional statistics counters are built when FIFO_RD_STAT_EN is defined.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_first,
  output logic                  m_last,
  input  logic                  stat_clr,
  output logic [31:0]           stat_words,
  output logic [15:0]           stat_bursts
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                  r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_pend_data;
  logic [BW-1:0]           r_beat_cnt;
  logic [TW-1:0]           r_to_cnt;
  logic                    r_m_valid, r_m_first, r_m_last;
  logic [DATA_WIDTH-1:0]   r_m_data;

  logic w_pend_vld, w_out_free, w_tmo, w_last_beat, w_move, w_pop, w_last_nxt;

  assign w_pend_vld  = (r_state == HOLD);
  assign w_out_free  = !r_m_valid || m_ready;
  assign w_tmo       = (r_to_cnt == TO_MAX);
  assign w_last_beat = (r_beat_cnt == LAST_BEAT);
  assign w_move      = w_pend_vld && w_out_free &&
                       ((!fifo_empty && en) || w_last_beat || w_tmo);
  assign w_pop       = rst_n && en && !fifo_empty && (!w_pend_vld || w_move);
  // A word with no successor popped alongside it cannot be followed in this burst.
  assign w_last_nxt  = w_last_beat || !w_pop;

  assign fifo_rd_en = w_pop;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_first    = r_m_first;
  assign m_last     = r_m_last;

  always_comb begin
    w_state_nxt = r_state;
    if (w_pop)       w_state_nxt = HOLD;
    else if (w_move) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_first   <= 1'b0;
      r_m_last    <= 1'b0;
      r_pend_data <= '0;
      r_beat_cnt  <= '0;
      r_to_cnt    <= '0;
    end else begin
      if (w_move) begin
        r_m_data   <= r_pend_data;
        r_m_valid  <= 1'b1;
        r_m_first  <= (r_beat_cnt == '0);
        r_m_last   <= w_last_nxt;
        r_beat_cnt <= w_last_nxt ? '0 : r_beat_cnt + BW'(1);
      end else if (w_out_free) begin
        r_m_valid <= 1'b0;
      end
      if (w_pop) r_pend_data <= fifo_dout;
      // Starvation timer: runs only while a word waits without a successor pop.
      if (w_pop || !w_pend_vld)  r_to_cnt <= '0;
      else if (!w_tmo)           r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

`ifdef FIFO_RD_STAT_EN
  logic [31:0] r_stat_words;
  logic [15:0] r_stat_bursts;

  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      r_stat_words  <= '0;
      r_stat_bursts <= '0;
    end else if (r_m_valid && m_ready) begin
      r_stat_words <= r_stat_words + 32'd1;
      if (r_m_last) r_stat_bursts <= r_stat_bursts + 16'd1;
    end
  end

  assign stat_words  = r_stat_words;
  assign stat_bursts = r_stat_bursts;
`else
  logic w_unused_stat_clr;
  assign w_unused_stat_clr = stat_clr;
  assign stat_words        = '0;
  assign stat_bursts       = '0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: FIFO model, popped-word queue, burst-position model.
module tb_fifo_burst_reader;
  localparam int DW = 16;
  localparam int BL = 4;
  localparam int TO = 16;
`ifdef FIFO_RD_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          m_ready = 1'b0;
  logic          stat_clr = 1'b0;
  logic          fifo_empty, fifo_rd_en, m_valid, m_first, m_last;
  logic [DW-1:0] fifo_dout, m_data;
  logic [31:0]   stat_words;
  logic [15:0]   stat_bursts;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_first(m_first), .m_last(m_last), .stat_clr(stat_clr),
    .stat_words(stat_words), .stat_bursts(stat_bursts)
  );

  // Show-ahead FIFO model
  logic [DW-1:0] mem [0:255];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp == rp);
  assign fifo_dout  = fifo_empty ? '0 : mem[rp[7:0]];
  always @(posedge clk) if (fifo_rd_en && !fifo_empty) rp <= rp + 1;

  task automatic push(input logic [DW-1:0] d);
    mem[wp[7:0]] = d;
    wp++;
  endtask

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  typedef struct { logic [DW-1:0] d; logic f; logic l; int c; } xrec_t;
  xrec_t         xlog[$];
  logic [DW-1:0] sb[$];
  int  idx = 0;
  int  exp_w = 0;
  int  exp_b = 0;
  bit  strict = 0;
  bit  bp_mode = 0;
  bit  after_rst = 0;
  bit  prev_stall = 0;
  logic [DW-1:0] prv_d;
  logic prv_f, prv_l;
  int  first_rd = -1;
  int  first_vld = -1;
  int  cnt_rd = 0;
  int  cnt_vld = 0;

  // Monitor: samples on the falling edge, i.e. the values the next rising edge acts on.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rd_en_in_reset", fifo_rd_en, 0);
      sb.delete();
      idx = 0; exp_w = 0; exp_b = 0;
      after_rst = 1; prev_stall = 0;
    end else begin
      if (after_rst) begin
        chk("valid_after_reset", m_valid, 0);
        after_rst = 0;
      end
      chk("stat_words", stat_words, STAT ? exp_w : 0);
      chk("stat_bursts", {16'd0, stat_bursts}, STAT ? exp_b : 0);
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prv_d);
        chk("stall_first", m_first, prv_f);
        chk("stall_last", m_last, prv_l);
        if (bp_mode && m_valid && !m_ready) chk("bp_rd_en", fifo_rd_en, 0);
      end
      if (fifo_rd_en) cnt_rd++;
      if (m_valid) cnt_vld++;
      if (fifo_rd_en && first_rd < 0) first_rd = cyc;
      if (m_valid && first_vld < 0) first_vld = cyc;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL out_unexpected: got %0h, expected no output word", m_data);
        end else begin
          chk("out_data", m_data, sb.pop_front());
        end
        chk("out_first", m_first, idx == 0);
        if (strict)             chk("out_last_strict", m_last, idx == BL - 1);
        else if (idx == BL - 1) chk("out_last_full", m_last, 1);
        idx = m_last ? 0 : idx + 1;
        xlog.push_back(xrec_t'{m_data, m_first, m_last, cyc});
      end
      if (fifo_rd_en) begin
        chk("rd_en_nonempty", fifo_empty, 0);
        sb.push_back(fifo_dout);
      end
      if (stat_clr) begin
        exp_w = 0; exp_b = 0;
      end else if (m_valid && m_ready) begin
        exp_w++;
        if (m_last) exp_b++;
      end
      prev_stall = m_valid && !m_ready;
      prv_d = m_data; prv_f = m_first; prv_l = m_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_xlog(input int n, input int budget, input string nm);
    int k = 0;
    while (xlog.size() < n && k < budget) begin
      step();
      k++;
    end
    if (xlog.size() < n) chk(nm, xlog.size(), n);
  endtask

  task automatic drain(input string nm);
    int k = 0;
    en = 1'b1; m_ready = 1'b1;
    while ((sb.size() != 0 || wp != rp || m_valid) && k < 400) begin
      step();
      k++;
    end
    chk(nm, (sb.size() == 0 && wp == rp && !m_valid), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prob;
    repeat (2) step();
    rst_n = 1'b1;

    // Empty FIFO after reset
    en = 1'b1; m_ready = 1'b1; cnt_rd = 0; cnt_vld = 0;
    repeat (50) step();
    chk("empty_rd_en_count", cnt_rd, 0);
    chk("empty_valid_count", cnt_vld, 0);

    // Two full bursts from a preloaded FIFO
    do_reset();
    en = 1'b0; strict = 1; xlog.delete(); first_rd = -1; first_vld = -1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    en = 1'b1;
    wait_xlog(8, 100, "t1_timeout");
    for (int i = 0; i < 8 && i < xlog.size(); i++) begin
      chk("t1_data", xlog[i].d, i + 1);
      chk("t1_first", xlog[i].f, (i % 4) == 0);
      chk("t1_last", xlog[i].l, (i % 4) == 3);
      chk("t1_back_to_back", xlog[i].c - xlog[0].c, i);
    end
    chk("t1_latency", first_vld - first_rd, 2);
    repeat (2) step();
    chk("t1_stat_words", stat_words, STAT ? 8 : 0);
    chk("t1_stat_bursts", {16'd0, stat_bursts}, STAT ? 2 : 0);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("t1_stat_clr_words", stat_words, 0);
    chk("t1_stat_clr_bursts", {16'd0, stat_bursts}, 0);
    strict = 0;

    // Short burst closed by starvation timeout
    xlog.delete();
    push(16'h00A1); push(16'h00A2); push(16'h00A3);
    wait_xlog(3, 100, "t2_timeout");
    if (xlog.size() >= 3) begin
      chk("t2_a1", xlog[0].d, 16'h00A1);
      chk("t2_a1_first", xlog[0].f, 1);
      chk("t2_a2", xlog[1].d, 16'h00A2);
      chk("t2_a2_adjacent", xlog[1].c - xlog[0].c, 1);
      chk("t2_a2_last", xlog[1].l, 0);
      chk("t2_a3", xlog[2].d, 16'h00A3);
      chk("t2_a3_last", xlog[2].l, 1);
      chk("t2_a3_gap", xlog[2].c - xlog[1].c, TO + 1);
    end
    push(16'h00B1);
    wait_xlog(4, 100, "t2b_timeout");
    if (xlog.size() >= 4) begin
      chk("t2_b1", xlog[3].d, 16'h00B1);
      chk("t2_b1_first", xlog[3].f, 1);
      chk("t2_b1_last", xlog[3].l, 1);
    end

    // Backpressure mid-burst
    do_reset();
    strict = 1; xlog.delete();
    for (int i = 1; i <= 12; i++) push(DW'(16'h0C00 + i));
    wait_xlog(2, 50, "t3_start_timeout");
    m_ready = 1'b0; bp_mode = 1;
    repeat (10) step();
    m_ready = 1'b1; bp_mode = 0;
    wait_xlog(12, 200, "t3_timeout");
    for (int i = 0; i < 12 && i < xlog.size(); i++) chk("t3_order", xlog[i].d, 16'h0C00 + i + 1);
    strict = 0;

    // Reset after beat 2 of a burst
    do_reset();
    xlog.delete();
    for (int i = 1; i <= 8; i++) push(DW'(16'h0D00 + i));
    wait_xlog(2, 50, "t4_start_timeout");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    xlog.delete();
    wait_xlog(1, 100, "t4_timeout");
    if (xlog.size() >= 1) chk("t4_first_after_reset", xlog[0].f, 1);
    drain("t4_drain");

    // Randomized traffic, checked by the scoreboard
    do_reset();
    prob = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) prob = $urandom_range(0, 2) == 0 ? 0 : ($urandom_range(0, 1) ? 30 : 90);
      if ((wp - rp) < 200 && $urandom_range(0, 99) < prob) push(DW'($urandom));
      m_ready  = $urandom_range(0, 3) != 0;
      en       = (c % 500 < 450) ? ($urandom_range(0, 7) != 0) : 1'b0;
      stat_clr = $urandom_range(0, 299) == 0;
      step();
    end
    stat_clr = 1'b0;
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
